apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that pairs with the team's 5-bit-address / 8-bit-data APB slave.
- Accepts read/write commands from a local valid/ready command port and runs the IDLE -> SETUP -> ACCESS sequence on the bus.
- Honours PREADY wait states and captures read data and the slave error flag.
- Returns a one-cycle response pulse and bounds wait states with a timeout counter.

Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADYm low before forced termination; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  local command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse, transfer finished.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- rsp_error  out  1  PSLVERRm sampled at completion, or timeout; valid with rsp_valid.
- rsp_timeout  out  1  transfer ended by timeout; valid with rsp_valid.
- PSELm  out  1  APB select.
- PENABLEm  out  1  APB enable.
- PWRITEm  out  1  APB direction.
- PADDRm  out  ADDR_W  APB address.
- PWDATAm  out  DATA_W  APB write data.
- PRDATAm  in  DATA_W  APB read data.
- PREADYm  in  1  APB ready from slave.
- PSLVERRm  in  1  APB slave error.
- P_stsMST  out  2  current state: IDLE=00, SETUP=01, ACCESS=10.

Behaviour:
- Reset (async, while Rst=1): every output goes to 0, P_stsMST=IDLE, and the wait counter clears. An in-flight transfer is abandoned with no rsp_valid. The first command can be accepted on the first edge after Rst deasserts.
- All bus outputs are registered; no combinational path from PREADYm to PSELm or PENABLEm.
- IDLE:
  - PSELm=0, PENABLEm=0, cmd_ready=1.
  - On accept, latch cmd_write/cmd_addr/cmd_wdata into PWRITEm/PADDRm/PWDATAm and go to SETUP.
  - PADDRm/PWDATAm/PWRITEm otherwise hold their last values.
- SETUP (exactly one cycle):
  - PSELm=1, PENABLEm=0, cmd_ready=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSELm=1, PENABLEm=1; address, data and direction held stable.
  - PREADYm=0 at an edge: stay in ACCESS and increment the wait counter.
  - PREADYm=1 at an edge (completion):
    - Capture rsp_rdata=PRDATAm on reads; rsp_rdata is unchanged on writes.
    - rsp_error=PSLVERRm, rsp_timeout=0.
    - rsp_valid=1 for the following cycle only.
    - Clear the wait counter.
  - cmd_ready=PREADYm in ACCESS, giving a combinational back-to-back accept.
    - If a command is accepted on the completion edge: latch it and go to SETUP (PSELm stays 1, PENABLEm drops to 0).
    - Otherwise go to IDLE.
  - Timeout (TIMEOUT_CYCLES>0): when the counter reaches TIMEOUT_CYCLES with PREADYm still 0:
    - Go to IDLE (PSELm=0, PENABLEm=0).
    - Pulse rsp_valid with rsp_error=1 and rsp_timeout=1; rsp_rdata unchanged.
    - No command is accepted on the timeout edge.
- Latency, accept edge to rsp_valid:
  - 0 wait states: rsp_valid high in the 3rd cycle after accept.
  - Each wait state adds 1 cycle.
- Back-to-back: the bus never returns to IDLE between chained transfers, sustaining 2 cycles per transfer.
- rsp_rdata and rsp_error hold their values between pulses; rsp_error and rsp_timeout are defined only while rsp_valid=1.
- The wait counter is wide enough for TIMEOUT_CYCLES with no wrap. PREADYm and PSLVERRm are ignored outside ACCESS.

Test Plan:
- Write with 0 waits:
  - Stimulus: cmd write addr=5'h03 data=8'hA5; slave PREADYm=1.
  - Response: P_stsMST goes IDLE->SETUP->ACCESS->IDLE; PADDRm=03 and PWDATAm=A5 stable across SETUP/ACCESS; rsp_valid pulses once with rsp_error=0.
- Read with 3 wait states:
  - Stimulus: cmd read addr=5'h1F; slave holds PREADYm=0 for 3 ACCESS cycles, then PRDATAm=8'h3C with PREADYm=1.
  - Response: PENABLEm high for 4 cycles; rsp_rdata=3C; rsp_valid arrives 6 cycles after accept.
- Back-to-back:
  - Stimulus: cmd_valid held high with write 01/11, then read 01.
  - Response: PSELm never drops; PENABLEm toggles 0,1,0,1; the second rsp_rdata equals 8'h11.
- Slave error:
  - Stimulus: read addr=5'h02 with PSLVERRm=1 at completion.
  - Response: rsp_valid=1, rsp_error=1, rsp_timeout=0; the next transfer reports rsp_error=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, slave never asserts PREADYm.
  - Response: after 4 ACCESS wait cycles, PSELm/PENABLEm go to 0 and rsp_valid pulses with rsp_error=1 and rsp_timeout=1.
- Reset mid-ACCESS:
  - Stimulus: assert Rst asynchronously during a wait state.
  - Response: all outputs go to 0 immediately, no rsp_valid; a new write after Rst deasserts completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB initiator with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              PSELm,
  output logic              PENABLEm,
  output logic              PWRITEm,
  output logic [ADDR_W-1:0] PADDRm,
  output logic [DATA_W-1:0] PWDATAm,
  input  logic [DATA_W-1:0] PRDATAm,
  input  logic              PREADYm,
  input  logic              PSLVERRm,
  output logic [1:0]        P_stsMST
);

  // Counter must hold TIMEOUT_CYCLES without wrapping; at least one bit.
  localparam int CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             accept;
  logic             complete;
  logic             timeout_hit;

  assign P_stsMST = state;

  // State register and wait-state counter.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state, command handshake and completion/timeout decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cmd_ready    = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready    = ~Rst;
        wait_cnt_nxt = '0;
        if (cmd_valid && !Rst) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_nxt = '0;
        state_nxt    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ready doubles as accept so a chained command skips IDLE.
        cmd_ready = PREADYm & ~Rst;
        if (PREADYm) begin
          complete     = 1'b1;
          wait_cnt_nxt = '0;
          if (cmd_valid && !Rst) begin
            accept    = 1'b1;
            state_nxt = ST_SETUP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          timeout_hit  = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = ST_IDLE;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Registered APB outputs; address/data/direction only change on accept.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      PSELm    <= 1'b0;
      PENABLEm <= 1'b0;
      PWRITEm  <= 1'b0;
      PADDRm   <= '0;
      PWDATAm  <= '0;
    end else begin
      PSELm    <= (state_nxt != ST_IDLE);
      PENABLEm <= (state_nxt == ST_ACCESS);
      if (accept) begin
        PWRITEm <= cmd_write;
        PADDRm  <= cmd_addr;
        PWDATAm <= cmd_wdata;
      end
    end
  end

  // Response pulse and captured read data / status.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= complete | timeout_hit;
      if (complete) begin
        if (!PWRITEm) begin
          rsp_rdata <= PRDATAm;
        end
        rsp_error   <= PSLVERRm;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed vector bench for apb_master_bridge
module tb_apb_master_bridge;

  logic       CLK = 1'b0;
  logic       Rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       rsp_timeout;
  logic       PSELm;
  logic       PENABLEm;
  logic       PWRITEm;
  logic [4:0] PADDRm;
  logic [7:0] PWDATAm;
  logic [7:0] PRDATAm = '0;
  logic       PREADYm = 1'b0;
  logic       PSLVERRm = 1'b0;
  logic [1:0] P_stsMST;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] slv_mem [0:31];

  apb_master_bridge #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSELm(PSELm), .PENABLEm(PENABLEm), .PWRITEm(PWRITEm), .PADDRm(PADDRm),
    .PWDATAm(PWDATAm), .PRDATAm(PRDATAm), .PREADYm(PREADYm), .PSLVERRm(PSLVERRm),
    .P_stsMST(P_stsMST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       write;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] rdata;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_lat;
    int         exp_pen;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction: issue the command, act as slave, check the response.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int acc;
    int pen;
    bit got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    chk({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cyc = 0; acc = 0; pen = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        got = 1;
        chk({tag, "_latency"}, cyc, v.exp_lat);
        chk({tag, "_penable_cycles"}, pen, v.exp_pen);
        chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
        chk({tag, "_error"}, {31'd0, rsp_error}, {31'd0, v.exp_err});
        chk({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        chk({tag, "_psel_after"}, {31'd0, PSELm}, 32'd0);
        PREADYm  = 1'b0;
        PSLVERRm = 1'b0;
      end else begin
        if (PENABLEm) pen++;
        if (cyc == 1) begin
          chk({tag, "_setup_sts"}, {30'd0, P_stsMST}, 32'd1);
          chk({tag, "_setup_bus"}, {30'd0, PSELm, PENABLEm}, 32'd2);
          chk({tag, "_setup_write"}, {31'd0, PWRITEm}, {31'd0, v.write});
          if (v.write) chk({tag, "_setup_wdata"}, {24'd0, PWDATAm}, {24'd0, v.wdata});
        end
        if (P_stsMST == 2'b10) begin
          acc++;
          chk({tag, "_access_addr"}, {27'd0, PADDRm}, {27'd0, v.addr});
          if (acc > v.waits) begin
            PREADYm  = 1'b1;
            PRDATAm  = v.rdata;
            PSLVERRm = v.slverr;
          end else begin
            PREADYm  = 1'b0;
            PRDATAm  = 8'hEE;
            PSLVERRm = ~v.slverr;
          end
        end else begin
          PREADYm  = 1'b0;
          PSLVERRm = 1'b0;
        end
      end
    end
    if (!got) chk({tag, "_rsp_seen"}, 32'd0, 32'd1);
    @(negedge CLK);
    chk({tag, "_pulse_once"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_back_idle"}, {30'd0, P_stsMST}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr  addr   wdata  waits rdata  err   exp_rd exp_e exp_t lat pen
    vecs[0] = '{1'b1, 5'h03, 8'hA5, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b0, 5'h1F, 8'h00, 3,  8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 5'h02, 8'h00, 0,  8'h77, 1'b1, 8'h77, 1'b1, 1'b0, 3, 1};
    vecs[3] = '{1'b1, 5'h02, 8'h5A, 1,  8'h00, 1'b0, 8'h77, 1'b0, 1'b0, 4, 2};
    vecs[4] = '{1'b0, 5'h0A, 8'h00, 99, 8'h00, 1'b0, 8'h77, 1'b1, 1'b1, 6, 4};
    vecs[5] = '{1'b1, 5'h1F, 8'h00, 2,  8'h00, 1'b0, 8'h77, 1'b0, 1'b0, 5, 3};
    vecs[6] = '{1'b0, 5'h15, 8'h00, 0,  8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0, 3, 1};
    vecs[7] = '{1'b1, 5'h10, 8'hFF, 3,  8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 6, 4};
    for (int i = 0; i < 32; i++) slv_mem[i] = 8'h00;

    // Reset state.
    #12;
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_error, rsp_timeout, PSELm, PENABLEm, PWRITEm, P_stsMST}, 32'd0);
    chk("reset_data", {11'd0, rsp_rdata, PADDRm, PWDATAm}, 32'd0);
    @(negedge CLK);
    Rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back: write 01/11 then read 01, cmd_valid held.
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h01; cmd_wdata = 8'h11;
    PREADYm = 1'b1; PSLVERRm = 1'b0;
    @(negedge CLK);
    chk("b2b_c1_bus", {29'd0, PSELm, PENABLEm, rsp_valid}, 32'b100);
    cmd_write = 1'b0;
    @(negedge CLK);
    chk("b2b_c2_bus", {29'd0, PSELm, PENABLEm, rsp_valid}, 32'b110);
    chk("b2b_c2_wdata", {23'd0, PWRITEm, PWDATAm}, {23'd0, 1'b1, 8'h11});
    if (PWRITEm) slv_mem[PADDRm] = PWDATAm;
    @(negedge CLK);
    chk("b2b_c3_bus", {29'd0, PSELm, PENABLEm, rsp_valid}, 32'b101);
    chk("b2b_c3_cmd", {26'd0, PWRITEm, PADDRm}, {26'd0, 1'b0, 5'h01});
    chk("b2b_c3_sts", {30'd0, P_stsMST}, 32'd1);
    cmd_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_c4_bus", {29'd0, PSELm, PENABLEm, rsp_valid}, 32'b110);
    PRDATAm = slv_mem[PADDRm];
    @(negedge CLK);
    chk("b2b_c5_rsp", {22'd0, rsp_valid, rsp_error, rsp_rdata}, {22'd0, 1'b1, 1'b0, 8'h11});
    chk("b2b_c5_idle", {29'd0, PSELm, P_stsMST}, 32'd0);
    PREADYm = 1'b0;

    // Asynchronous reset during a wait state.
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h04;
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pre_access", {30'd0, P_stsMST}, 32'd2);
    #2 Rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {cmd_ready, rsp_valid, rsp_error, rsp_timeout, PSELm, PENABLEm, PWRITEm, P_stsMST}, 32'd0);
    chk("rst_async_data", {11'd0, rsp_rdata, PADDRm, PWDATAm}, 32'd0);
    @(negedge CLK);
    Rst = 1'b0;
    @(negedge CLK);
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    run_vec('{1'b1, 5'h0C, 8'h99, 1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4, 2}, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
